// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the CNN datapath blocks: the loader FSM state
// type, the default frame geometry and pixel width shared with the
// convolution engine, and a helper that sizes raster pointers.
package cnn_pkg;

  // Default frame geometry and pixel width, shared with the conv engine.
  localparam int IFMAP_HEIGHT_DEF = 6;
  localparam int IFMAP_WIDTH_DEF  = 6;
  localparam int DATA_WIDTH_DEF   = 8;

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    FULL    = 2'd2,
    RELEASE = 2'd3
  } loader_state_t;

  // Pointer width for a dimension of n entries; never narrower than 1 bit
  // so that a 1-wide dimension still has a legal counter.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ifmap_wr_ptr.sv
// ifmap_wr_ptr
// Raster-order row/column write pointer for the ifmap loader.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   advance        step one position (column fastest, row on column wrap)
//   clear          resync the pointer to (0,0)
//   wrap_done      final pixel of the frame taken; return to (0,0)
//   row, col       current write position
module ifmap_wr_ptr
  import cnn_pkg::*;
#(
  parameter int HEIGHT = IFMAP_HEIGHT_DEF,
  parameter int WIDTH  = IFMAP_WIDTH_DEF,
  parameter int ROW_W  = ptr_width(HEIGHT),
  parameter int COL_W  = ptr_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             clear,
  input  logic             wrap_done,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);

  // The end-of-frame return is driven by the owner through wrap_done, so
  // the counter never has to know the frame height to finish a frame;
  // clear has the same effect and takes priority over a plain advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clear || wrap_done) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifmap_loader.sv
// ifmap_loader
// Streaming input-feature-map loader. Pixels arrive in raster order over a
// valid/ready stream and are assembled into a register array that feeds the
// convolution engine directly. The frame is held until the engine reports
// done, and the loader waits for that done to drop before re-arming.
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   s_valid/s_ready input stream handshake
//   s_data          pixel, row-major with column fastest
//   s_last          end-of-frame marker (checked only with the macro)
//   ifmap           assembled frame, registered
//   frame_valid     frame complete and stable (engine en)
//   frame_release   engine done_conv
//   frame_error     sticky framing error
// Configuration macro: IFMAP_LOADER_LAST_CHECK_EN enables s_last checking
// and frame_error; without it s_last is ignored and frame_error is 0.
module ifmap_loader
  import cnn_pkg::*;
#(
  parameter int IFMAP_HEIGHT = IFMAP_HEIGHT_DEF,
  parameter int IFMAP_WIDTH  = IFMAP_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [0:IFMAP_HEIGHT-1][0:IFMAP_WIDTH-1][DATA_WIDTH-1:0] ifmap,
  output logic                  frame_valid,
  input  logic                  frame_release,
  output logic                  frame_error
);

  localparam int ROW_W = ptr_width(IFMAP_HEIGHT);
  localparam int COL_W = ptr_width(IFMAP_WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IFMAP_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IFMAP_WIDTH - 1);

  loader_state_t    state;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic             handshake;
  logic             at_last;
  logic             frame_done;
  logic             resync;

  // Ready and valid come straight from the registered state, so nothing
  // on the input side can reach s_ready combinationally.
  assign s_ready     = (state == LOAD);
  assign frame_valid = (state == FULL);
  assign handshake   = s_valid && s_ready;
  assign at_last     = (wr_row == ROW_MAX) && (wr_col == COL_MAX);
  assign frame_done  = handshake && at_last;

`ifdef IFMAP_LOADER_LAST_CHECK_EN
  // An early s_last throws the partial frame away by resyncing the pointer;
  // a missing s_last on the final pixel is only flagged.
  assign resync = handshake && s_last && !at_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_error <= 1'b0;
    end else if (resync || (frame_done && !s_last)) begin
      frame_error <= 1'b1;
    end
  end
`else
  logic unused_last;

  assign resync      = 1'b0;
  assign frame_error = 1'b0;
  assign unused_last = s_last;
`endif

  ifmap_wr_ptr #(
    .HEIGHT (IFMAP_HEIGHT),
    .WIDTH  (IFMAP_WIDTH),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_wr_ptr (
    .clk       (clk),
    .reset_n   (reset_n),
    .advance   (handshake),
    .clear     (resync),
    .wrap_done (frame_done),
    .row       (wr_row),
    .col       (wr_col)
  );

  // Frame storage: only accepted beats write, so the array is frozen
  // whenever the loader is not in LOAD. It is never cleared between frames
  // because the next complete frame overwrites every element.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifmap <= '0;
    end else if (handshake) begin
      ifmap[wr_row][wr_col] <= s_data;
    end
  end

  // Loader FSM. RELEASE waits for done_conv to drop so that a done which is
  // still high from the previous frame cannot release the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= LOAD;
        LOAD:    if (frame_done)     state <= FULL;
        FULL:    if (frame_release)  state <= RELEASE;
        RELEASE: if (!frame_release) state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_loader.sv
// tb_ifmap_loader
// Directed bench for ifmap_loader with a frame-level reference model that is
// compared against the DUT on every falling clock edge, plus literal checks
// of selected pixels and handshake timing.
module tb_ifmap_loader;

  localparam int H  = 6;
  localparam int W  = 6;
  localparam int DW = 8;
  localparam int N  = H * W;

  typedef logic [0:H-1][0:W-1][DW-1:0] frame_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  frame_t        ifmap;
  logic          frame_valid;
  logic          frame_release = 1'b0;
  logic          frame_error;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  ifmap_loader #(
    .IFMAP_HEIGHT (H),
    .IFMAP_WIDTH  (W),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .ifmap         (ifmap),
    .frame_valid   (frame_valid),
    .frame_release (frame_release),
    .frame_error   (frame_error)
  );

  always #5 clk = ~clk;

  // Reference model: the frame is a linear count of accepted pixels mapped
  // onto row = k / W, col = k % W. The loader is either booting, collecting,
  // holding a finished frame, or waiting for done to drop.
  localparam int PH_BOOT = 0, PH_COLLECT = 1, PH_HOLD = 2, PH_DRAIN = 3;
  int     m_phase;
  int     m_count;
  frame_t m_ifmap;
  logic   m_err;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= PH_BOOT;
      m_count <= 0;
      m_ifmap <= '0;
      m_err   <= 1'b0;
    end else begin
      case (m_phase)
        PH_BOOT: m_phase <= PH_COLLECT;
        PH_COLLECT: begin
          if (s_valid) begin
            m_ifmap[m_count / W][m_count % W] <= s_data;
`ifdef IFMAP_LOADER_LAST_CHECK_EN
            if (s_last && m_count != N - 1) begin
              m_err   <= 1'b1;
              m_count <= 0;
            end else
`endif
            if (m_count == N - 1) begin
              m_count <= 0;
              m_phase <= PH_HOLD;
`ifdef IFMAP_LOADER_LAST_CHECK_EN
              if (!s_last) m_err <= 1'b1;
`endif
            end else begin
              m_count <= m_count + 1;
            end
          end
        end
        PH_HOLD:  if (frame_release)  m_phase <= PH_DRAIN;
        default:  if (!frame_release) m_phase <= PH_COLLECT;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkFrame(input string name, input frame_t act, input frame_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge, where all
  // outputs are settled from the previous rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_s_ready", {31'd0, s_ready}, {31'd0, m_phase == PH_COLLECT});
      checkOutput("model_frame_valid", {31'd0, frame_valid}, {31'd0, m_phase == PH_HOLD});
      checkOutput("model_frame_error", {31'd0, frame_error}, {31'd0, m_err});
      checkFrame("model_ifmap", ifmap, m_ifmap);
    end
  end

  // Drive all inputs just after a falling edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                               input logic l, input logic rel);
    @(negedge clk);
    s_valid       = v;
    s_data        = d;
    s_last        = l;
    frame_release = rel;
  endtask

  // Present one beat and hold it until the loader is ready; the rising edge
  // following a ready falling-edge sample is the one that captures it.
  task automatic sendBeat(input logic [DW-1:0] d, input logic l);
    int waited = 0;
    applyStimulus(1'b1, d, l, 1'b0);
    while (!s_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      failures++;
      $display("[TB] FAIL beat_timeout actual=no_ready required=ready data=%0h", d);
    end
  endtask

  frame_t snap;

  initial begin
    // Reset held for three cycles
    #2 reset_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_s_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("reset_frame_error", {31'd0, frame_error}, 32'd0);
    checkFrame("reset_ifmap", ifmap, '0);
    reset_n = 1'b1;
    #1 checkOutput("boot_idle_not_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    checkOutput("boot_load_ready", {31'd0, s_ready}, 32'd1);

    // Frame 1: continuous 1..36
    for (int i = 1; i <= N; i++) begin
      s_valid = 1'b1; s_data = DW'(i); s_last = (i == N);
      @(negedge clk);
    end
    checkOutput("f1_frame_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("f1_s_ready_low", {31'd0, s_ready}, 32'd0);
    checkOutput("f1_px00", {24'd0, ifmap[0][0]}, 32'd1);
    checkOutput("f1_px23", {24'd0, ifmap[2][3]}, 32'd16);
    checkOutput("f1_px55", {24'd0, ifmap[5][5]}, 32'd36);
    checkOutput("model_px23", {24'd0, m_ifmap[2][3]}, 32'd16);
    snap = ifmap;

    // Release for three cycles with a beat held valid the whole time
    applyStimulus(1'b1, 8'd51, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd51, 1'b0, 1'b1);
    checkOutput("rel_frame_valid_drop", {31'd0, frame_valid}, 32'd0);
    checkOutput("rel_s_ready_low", {31'd0, s_ready}, 32'd0);
    applyStimulus(1'b1, 8'd51, 1'b0, 1'b1);
    checkFrame("rel_ifmap_frozen", ifmap, snap);
    applyStimulus(1'b1, 8'd51, 1'b0, 1'b0);
    checkOutput("rel_still_not_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    checkOutput("rel_s_ready_rise", {31'd0, s_ready}, 32'd1);
    checkFrame("rel_ifmap_frozen2", ifmap, snap);

    // Frame 2: 51..86 with valid toggling; beat 51 is already waiting
    for (int i = 2; i <= N; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
      if (i == 2)
        checkOutput("f2_first_px00", {24'd0, ifmap[0][0]}, 32'd51);
      sendBeat(DW'(50 + i), i == N);
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("f2_frame_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("f2_px00", {24'd0, ifmap[0][0]}, 32'd51);
    checkOutput("f2_px23", {24'd0, ifmap[2][3]}, 32'd66);
    checkOutput("f2_px55", {24'd0, ifmap[5][5]}, 32'd86);

    // Short release, then a frame aborted by reset after ten beats
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) sendBeat(DW'(200 + i), 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    checkFrame("midreset_ifmap", ifmap, '0);
    checkOutput("midreset_frame_valid", {31'd0, frame_valid}, 32'd0);
    reset_n = 1'b1;

    // Frame 3: i*7 loaded after the aborted frame
    for (int i = 1; i <= N; i++) sendBeat(DW'(i * 7), i == N);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("f3_frame_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("f3_px00", {24'd0, ifmap[0][0]}, 32'd7);
    checkOutput("f3_px55", {24'd0, ifmap[5][5]}, 32'd252);

`ifdef IFMAP_LOADER_LAST_CHECK_EN
    // Early s_last on beat 20, then a clean frame
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) sendBeat(DW'(8'h80 + i), i == 20);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("early_last_error", {31'd0, frame_error}, 32'd1);
    checkOutput("early_last_still_load", {31'd0, s_ready}, 32'd1);
    for (int i = 1; i <= N; i++) begin
      sendBeat(DW'(8'hC0 + i), i == N);
      if (i == 2)
        checkOutput("resync_px00", {24'd0, ifmap[0][0]}, 32'hC1);
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("clean_frame_valid", {31'd0, frame_valid}, 32'd1);
    checkOutput("clean_error_sticky", {31'd0, frame_error}, 32'd1);
    checkOutput("clean_px55", {24'd0, ifmap[5][5]}, 32'hE4);
`else
    checkOutput("no_macro_error_zero", {31'd0, frame_error}, 32'd0);
`endif

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
